// File: rtl/fu_issue_sequencer.sv
// fu_issue_sequencer: DE-side driver that turns one ALU request into the FU_STAGE strobe
// sequence (aluop, op1, op2 writes, then op3 read) and returns the captured result.
module fu_issue_sequencer #(
    parameter int DBITS          = 32,
    parameter int ALUOPBITS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ALUOPBITS-1:0] req_aluop,
    input  logic [DBITS-1:0]     req_op1,
    input  logic [DBITS-1:0]     req_op2,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DBITS-1:0]     rsp_data,
    output logic [DBITS+3:0]     from_DE_to_FU,
    input  logic [DBITS+2:0]     from_FU_to_DE,
    output logic                 err_timeout,
    output logic [15:0]          ops_done
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, S_ALUOP, S_OP1, S_OP2, WAIT_RES, S_READ, RESP} state_t;

    typedef struct packed {
        logic [ALUOPBITS-1:0] aluop;
        logic [DBITS-1:0]     op1;
        logic [DBITS-1:0]     op2;
    } req_t;

    // Field order matches the from_DE_to_FU bus layout, so the struct maps straight onto it.
    typedef struct packed {
        logic             rd_op3;
        logic [DBITS-1:0] wr_data;
        logic             wr_op2;
        logic             wr_op1;
        logic             wr_aluop;
    } strobe_t;

    state_t           state, state_nxt;
    req_t             req_q, req_nxt;
    strobe_t          strb_q, strb_nxt;
    logic             rsp_valid_q, rsp_valid_nxt;
    logic [DBITS-1:0] rsp_data_q, rsp_data_nxt;
    logic             err_q, err_nxt;
    logic [15:0]      ops_q, ops_nxt;
    logic [TW-1:0]    timer_q, timer_nxt;

    logic [DBITS-1:0] op3;
    logic             op2_taken, res_valid, unused_csr;

    assign op3        = from_FU_to_DE[DBITS-1:0];
    assign op2_taken  = from_FU_to_DE[DBITS];
    assign unused_csr = from_FU_to_DE[DBITS+1];
    assign res_valid  = from_FU_to_DE[DBITS+2];

    always_comb begin
        state_nxt     = state;
        req_nxt       = req_q;
        rsp_valid_nxt = rsp_valid_q;
        rsp_data_nxt  = rsp_data_q;
        err_nxt       = err_q;
        ops_nxt       = ops_q;
        timer_nxt     = timer_q;
        strb_nxt      = '0;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = S_ALUOP;
                    req_nxt   = '{aluop: req_aluop, op1: req_op1, op2: req_op2};
                end
            end
            S_ALUOP: state_nxt = S_OP1;
            S_OP1:   state_nxt = S_OP2;
            S_OP2: begin
                if (op2_taken) state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                if (res_valid) begin
                    rsp_data_nxt = op3;
                    timer_nxt    = '0;
                    state_nxt    = S_READ;
                end else if (timer_q == TIMER_LAST) begin
                    // Timer parks at the limit; the error flag stays up until reset.
                    err_nxt = 1'b1;
                end else begin
                    timer_nxt = timer_q + TW'(1);
                end
            end
            S_READ: begin
                state_nxt     = RESP;
                ops_nxt       = ops_q + 16'd1;
                rsp_valid_nxt = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Strobes are a function of the state being entered, so they register on the entry edge.
        case (state_nxt)
            S_ALUOP: begin
                strb_nxt.wr_aluop = 1'b1;
                strb_nxt.wr_data  = DBITS'(req_nxt.aluop);
            end
            S_OP1: begin
                strb_nxt.wr_op1  = 1'b1;
                strb_nxt.wr_data = req_nxt.op1;
            end
            S_OP2: begin
                strb_nxt.wr_op2  = 1'b1;
                strb_nxt.wr_data = req_nxt.op2;
            end
            S_READ:  strb_nxt.rd_op3 = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            req_q       <= '0;
            strb_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            ops_q       <= '0;
            timer_q     <= '0;
        end else begin
            state       <= state_nxt;
            req_q       <= req_nxt;
            strb_q      <= strb_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_data_q  <= rsp_data_nxt;
            err_q       <= err_nxt;
            ops_q       <= ops_nxt;
            timer_q     <= timer_nxt;
        end
    end

    // Gated with reset_n so nothing is offered while the block is held in reset.
    assign req_ready     = (state == IDLE) && reset_n;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign from_DE_to_FU = strb_q;
    assign err_timeout   = err_q;
    assign ops_done      = ops_q;

endmodule

// File: tb/tb_fu_issue_sequencer.sv
// tb_fu_issue_sequencer: drives fu_issue_sequencer against a behavioural FU_STAGE/ALU model
// and checks results, strobe protocol, handshakes, timeout and reset.
module tb_fu_issue_sequencer;
    localparam int DBITS = 32;
    localparam int ALUOPBITS = 4;
    localparam int TOUT = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [3:0]  req_aluop = '0;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;
    logic        req_ready, rsp_valid, err_timeout;
    logic [31:0] rsp_data;
    logic [35:0] from_DE_to_FU;
    logic [34:0] from_FU_to_DE;
    logic [15:0] ops_done;

    int npass = 0;
    int ntot = 0;
    int exp_ops = 0;

    always #5 clk = ~clk;

    fu_issue_sequencer #(.DBITS(DBITS), .ALUOPBITS(ALUOPBITS), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_aluop(req_aluop),
        .req_op1(req_op1), .req_op2(req_op2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .from_DE_to_FU(from_DE_to_FU), .from_FU_to_DE(from_FU_to_DE),
        .err_timeout(err_timeout), .ops_done(ops_done)
    );

    logic wr_aluop, wr_op1, wr_op2, rd_op3;
    logic [31:0] wr_data;
    assign wr_aluop = from_DE_to_FU[0];
    assign wr_op1   = from_DE_to_FU[1];
    assign wr_op2   = from_DE_to_FU[2];
    assign wr_data  = from_DE_to_FU[34:3];
    assign rd_op3   = from_DE_to_FU[35];

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op == 4'd0) ? a + b : a - b;
    endfunction

    // Behavioural FU_STAGE: accepts OP2 after cfg_op1_delay cycles of wr_op2, result after cfg_comp_delay.
    int cfg_op1_delay = 0;
    int cfg_comp_delay = 0;
    logic [3:0]  fu_aluop = '0;
    logic [31:0] fu_op1 = '0, fu_op2 = '0, fu_op3 = '0;
    logic        fu_res = 1'b0, fu_busy = 1'b0;
    int          fu_cnt = 0, fu_wait = 0;
    logic        csr0;
    assign csr0 = wr_op2 && (fu_wait >= cfg_op1_delay);
    assign from_FU_to_DE = {fu_res, 1'b0, csr0, fu_op3};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fu_aluop <= '0; fu_op1 <= '0; fu_op2 <= '0; fu_op3 <= '0;
            fu_res <= 1'b0; fu_busy <= 1'b0; fu_cnt <= 0; fu_wait <= 0;
        end else begin
            if (wr_aluop) fu_aluop <= wr_data[3:0];
            if (wr_op1) fu_op1 <= wr_data;
            if (wr_op2) begin
                if (csr0) begin
                    fu_op2 <= wr_data; fu_busy <= 1'b1; fu_cnt <= cfg_comp_delay; fu_wait <= 0;
                end else begin
                    fu_wait <= fu_wait + 1;
                end
            end
            if (fu_busy) begin
                if (fu_cnt == 0) begin
                    fu_res <= 1'b1; fu_op3 <= alu(fu_aluop, fu_op1, fu_op2); fu_busy <= 1'b0;
                end else begin
                    fu_cnt <= fu_cnt - 1;
                end
            end
            if (rd_op3) fu_res <= 1'b0;
        end
    end

    // Protocol monitor: cumulative counters, sampled on the falling edge.
    int n_aluop = 0, n_op1 = 0, n_op2 = 0, n_rd = 0, n_rspv = 0;
    int multi = 0, idle_bad = 0, op2_unstable = 0, rsp_unstable = 0, rr_bad = 0;
    logic [31:0] d_aluop = '0, d_op1 = '0, d_op2 = '0, prev_data = '0, prev_rsp = '0;
    logic prev_aluop = 0, prev_op1 = 0, prev_op2 = 0, prev_rd = 0, prev_rspv = 0, err_prev = 0, after_op2 = 0;
    int ord_q[$];
    int wcnt = 0, err_first_wait = -1;

    always @(negedge clk) begin
        if (reset_n) begin
            int ns;
            ns = int'(wr_aluop) + int'(wr_op1) + int'(wr_op2) + int'(rd_op3);
            if (ns > 1) multi++;
            if (ns == 0 && wr_data != 32'h0) idle_bad++;
            if (wr_aluop) begin n_aluop++; d_aluop = wr_data; if (!prev_aluop) ord_q.push_back(0); end
            if (wr_op1) begin n_op1++; d_op1 = wr_data; if (!prev_op1) ord_q.push_back(1); end
            if (wr_op2) begin
                n_op2++; d_op2 = wr_data;
                if (!prev_op2) ord_q.push_back(2);
                else if (wr_data != prev_data) op2_unstable++;
                after_op2 = 1'b1; wcnt = 0;
            end
            if (rd_op3) begin n_rd++; if (!prev_rd) ord_q.push_back(3); after_op2 = 1'b0; end
            if (ns == 0 && after_op2) begin
                if (err_timeout && !err_prev) err_first_wait = wcnt;
                wcnt++;
            end
            if (rsp_valid) begin
                n_rspv++;
                if (prev_rspv && rsp_data != prev_rsp) rsp_unstable++;
            end
            if (req_ready && (ns > 0 || rsp_valid || after_op2)) rr_bad++;
            prev_aluop = wr_aluop; prev_op1 = wr_op1; prev_op2 = wr_op2; prev_rd = rd_op3;
            prev_data = wr_data; prev_rspv = rsp_valid; prev_rsp = rsp_data; err_prev = err_timeout;
        end
    end

    function automatic int ord_code(input int from);
        int c = 0;
        for (int i = from; i < ord_q.size(); i++) c = c * 10 + ord_q[i] + 1;
        return c;
    endfunction

    // Stimulus driver only: one transaction from offer to response handshake.
    task automatic do_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int d1, input int dc, input int stall,
                          output logic [31:0] data, output bit hung);
        int t;
        @(negedge clk);
        cfg_op1_delay = d1; cfg_comp_delay = dc;
        req_aluop = op; req_op1 = a; req_op2 = b; req_valid = 1'b1;
        rsp_ready = (stall == 0);
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        req_valid = 1'b0; req_aluop = 4'($urandom); req_op1 = $urandom; req_op2 = $urandom;
        t = 0;
        while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
        hung = !rsp_valid;
        data = rsp_data;
        repeat (stall) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        ntot++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got %b want 0", req_ready); else npass++;
        ntot++; if ({rsp_valid, err_timeout} !== 2'b00) $display("FAIL reset_flags got %b want 00", {rsp_valid, err_timeout}); else npass++;
        ntot++; if (from_DE_to_FU !== 36'h0) $display("FAIL reset_strobes got %h want 0", from_DE_to_FU); else npass++;
        ntot++; if ({rsp_data, ops_done} !== 48'h0) $display("FAIL reset_data got %h want 0", {rsp_data, ops_done}); else npass++;
        reset_n = 1'b1;
        #1;
        ntot++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", req_ready); else npass++;
        exp_ops = 0;
    endtask

    task automatic test_single_add();
        int s_a = n_aluop, s_1 = n_op1, s_2 = n_op2, s_r = n_rd, s_v = n_rspv, s_o = ord_q.size();
        logic [31:0] d; bit hung;
        do_txn(4'd0, 32'h5, 32'h3, 0, 1, 0, d, hung);
        exp_ops++;
        ntot++; if (hung !== 1'b0) $display("FAIL add_hang no response"); else npass++;
        ntot++; if (d !== 32'h8) $display("FAIL add_result got %h want 00000008", d); else npass++;
        ntot++; if (n_rspv - s_v !== 1) $display("FAIL add_rsp_cycles got %0d want 1", n_rspv - s_v); else npass++;
        ntot++; if (ops_done !== 16'(exp_ops)) $display("FAIL add_ops_done got %0d want %0d", ops_done, exp_ops); else npass++;
        ntot++; if (ord_code(s_o) !== 1234) $display("FAIL add_order got %0d want 1234", ord_code(s_o)); else npass++;
        ntot++; if ({n_aluop - s_a, n_op1 - s_1, n_op2 - s_2, n_rd - s_r} !== {32'd1, 32'd1, 32'd1, 32'd1})
            $display("FAIL add_strobe_counts got %0d %0d %0d %0d want 1 1 1 1", n_aluop - s_a, n_op1 - s_1, n_op2 - s_2, n_rd - s_r);
        else npass++;
        ntot++; if ({d_aluop, d_op1, d_op2} !== {32'h0, 32'h5, 32'h3})
            $display("FAIL add_wr_data got %h %h %h want 0 5 3", d_aluop, d_op1, d_op2);
        else npass++;
    endtask

    task automatic test_op1_wait();
        int s_2 = n_op2, s_u = op2_unstable;
        logic [31:0] a = $urandom, b = $urandom, d; bit hung;
        do_txn(4'd0, a, b, 6, 2, 0, d, hung);
        exp_ops++;
        ntot++; if (n_op2 - s_2 !== 7) $display("FAIL op1wait_op2_cycles got %0d want 7", n_op2 - s_2); else npass++;
        ntot++; if (op2_unstable - s_u !== 0 || d_op2 !== b) $display("FAIL op1wait_op2_data got %h want %h", d_op2, b); else npass++;
        ntot++; if (hung || d !== alu(4'd0, a, b)) $display("FAIL op1wait_result got %h want %h", d, alu(4'd0, a, b)); else npass++;
    endtask

    task automatic test_sub_stall();
        int s_v = n_rspv, s_u = rsp_unstable, s_rr = rr_bad;
        logic [31:0] d; bit hung;
        do_txn(4'd1, 32'h0, 32'h1, 0, 1, 10, d, hung);
        exp_ops++;
        ntot++; if (hung || d !== 32'hFFFF_FFFF) $display("FAIL sub_result got %h want ffffffff", d); else npass++;
        ntot++; if (n_rspv - s_v !== 11) $display("FAIL sub_rsp_cycles got %0d want 11", n_rspv - s_v); else npass++;
        ntot++; if (rsp_unstable - s_u !== 0) $display("FAIL sub_rsp_stable got %0d changes want 0", rsp_unstable - s_u); else npass++;
        ntot++; if (rr_bad - s_rr !== 0) $display("FAIL sub_req_ready got %0d busy-ready cycles want 0", rr_bad - s_rr); else npass++;
        ntot++; if (ops_done !== 16'(exp_ops)) $display("FAIL sub_ops_done got %0d want %0d", ops_done, exp_ops); else npass++;
    endtask

    task automatic test_random();
        int s_m = multi, s_i = idle_bad, s_u = op2_unstable + rsp_unstable, s_rr = rr_bad;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] op = 4'($urandom_range(0, 1));
            logic [31:0] a = $urandom, b = $urandom, d;
            int d1 = $urandom_range(0, 4), dc = $urandom_range(0, 4), st = $urandom_range(0, 3);
            int s_v = n_rspv, s_2 = n_op2, s_o = ord_q.size();
            bit hung;
            do_txn(op, a, b, d1, dc, st, d, hung);
            exp_ops++;
            ntot++; if (hung || d !== alu(op, a, b)) $display("FAIL rand%0d_result got %h want %h", k, d, alu(op, a, b)); else npass++;
            ntot++; if (n_rspv - s_v !== st + 1) $display("FAIL rand%0d_rsp_cycles got %0d want %0d", k, n_rspv - s_v, st + 1); else npass++;
            ntot++; if (n_op2 - s_2 !== d1 + 1) $display("FAIL rand%0d_op2_cycles got %0d want %0d", k, n_op2 - s_2, d1 + 1); else npass++;
            ntot++; if (ord_code(s_o) !== 1234) $display("FAIL rand%0d_order got %0d want 1234", k, ord_code(s_o)); else npass++;
            ntot++; if (ops_done !== 16'(exp_ops)) $display("FAIL rand%0d_ops_done got %0d want %0d", k, ops_done, exp_ops); else npass++;
        end
        ntot++; if (multi - s_m !== 0) $display("FAIL rand_onehot got %0d multi-strobe cycles want 0", multi - s_m); else npass++;
        ntot++; if (idle_bad - s_i !== 0) $display("FAIL rand_idle_data got %0d nonzero cycles want 0", idle_bad - s_i); else npass++;
        ntot++; if (op2_unstable + rsp_unstable - s_u !== 0) $display("FAIL rand_stability got %0d changes want 0", op2_unstable + rsp_unstable - s_u); else npass++;
        ntot++; if (rr_bad - s_rr !== 0) $display("FAIL rand_req_ready got %0d busy-ready cycles want 0", rr_bad - s_rr); else npass++;
        ntot++; if (err_timeout !== 1'b0) $display("FAIL rand_no_timeout got %b want 0", err_timeout); else npass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] op[3]; logic [31:0] a[3], b[3];
        logic [31:0] got[$];
        int acc = 0, t = 0, gap_bad = 0;
        bit took = 0, prev_v = 0;
        for (int i = 0; i < 3; i++) begin op[i] = 4'($urandom_range(0, 1)); a[i] = $urandom; b[i] = $urandom; end
        @(negedge clk);
        cfg_op1_delay = 0; cfg_comp_delay = 1; rsp_ready = 1'b1;
        req_aluop = op[0]; req_op1 = a[0]; req_op2 = b[0]; req_valid = 1'b1;
        while ((acc < 3 || got.size() < 3) && t < 400) begin
            if (prev_v && acc < 3 && !req_ready) gap_bad++;
            if (req_valid && req_ready) begin acc++; took = 1; end else took = 0;
            if (rsp_valid) got.push_back(rsp_data);
            prev_v = rsp_valid;
            @(negedge clk); t++;
            if (took) begin
                if (acc < 3) begin req_aluop = op[acc]; req_op1 = a[acc]; req_op2 = b[acc]; end
                else req_valid = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
        rsp_ready = 1'b0;
        exp_ops += 3;
        ntot++; if (acc !== 3) $display("FAIL b2b_accepts got %0d want 3", acc); else npass++;
        ntot++; if (got.size() !== 3) $display("FAIL b2b_responses got %0d want 3", got.size()); else npass++;
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            ntot++; if (got[i] !== alu(op[i], a[i], b[i])) $display("FAIL b2b_result%0d got %h want %h", i, got[i], alu(op[i], a[i], b[i])); else npass++;
        end
        ntot++; if (gap_bad !== 0) $display("FAIL b2b_idle_gap got %0d late accepts want 0", gap_bad); else npass++;
        ntot++; if (ops_done !== 16'(exp_ops)) $display("FAIL b2b_ops_done got %0d want %0d", ops_done, exp_ops); else npass++;
    endtask

    task automatic test_timeout();
        logic [31:0] a = $urandom, b = $urandom, d; bit hung;
        do_txn(4'd1, a, b, 0, 20, 0, d, hung);
        exp_ops++;
        ntot++; if (err_first_wait !== 8) $display("FAIL timeout_rise got after %0d wait cycles want 8", err_first_wait); else npass++;
        ntot++; if (hung || d !== alu(4'd1, a, b)) $display("FAIL timeout_result got %h want %h", d, alu(4'd1, a, b)); else npass++;
        do_txn(4'd0, 32'h10, 32'h20, 0, 0, 0, d, hung);
        exp_ops++;
        ntot++; if (err_timeout !== 1'b1) $display("FAIL timeout_sticky got %b want 1", err_timeout); else npass++;
        ntot++; if (hung || d !== 32'h30) $display("FAIL timeout_next_result got %h want 00000030", d); else npass++;
    endtask

    task automatic test_reset_mid();
        int s_v;
        logic [31:0] d; bit hung;
        @(negedge clk);
        cfg_op1_delay = 0; cfg_comp_delay = 20;
        req_aluop = 4'd0; req_op1 = 32'h1234; req_op2 = 32'h1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        ntot++; if ({req_ready, rsp_valid, err_timeout} !== 3'b000) $display("FAIL midreset_flags got %b want 000", {req_ready, rsp_valid, err_timeout}); else npass++;
        ntot++; if ({from_DE_to_FU, rsp_data, ops_done} !== 84'h0) $display("FAIL midreset_outputs got %h want 0", {from_DE_to_FU, rsp_data, ops_done}); else npass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_ops = 0;
        s_v = n_rspv;
        repeat (3) @(negedge clk);
        ntot++; if (n_rspv - s_v !== 0) $display("FAIL midreset_spurious got %0d rsp cycles want 0", n_rspv - s_v); else npass++;
        do_txn(4'd0, 32'h0000_0100, 32'h0000_0023, 1, 1, 0, d, hung);
        exp_ops++;
        ntot++; if (hung || d !== 32'h123) $display("FAIL midreset_result got %h want 00000123", d); else npass++;
        ntot++; if (ops_done !== 16'(exp_ops)) $display("FAIL midreset_ops_done got %0d want %0d", ops_done, exp_ops); else npass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_add();
        test_op1_wait();
        test_sub_stall();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
